// File: rtl/uart_scoreboard.sv
// In-order scoreboard for the UART loopback: queues launched TX bytes, compares each
// received byte against the queue head and keeps saturating event counters plus sticky flags.
module uart_scoreboard #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_aresetn,
    input  logic                    i_clr,
    input  logic                    i_tx_start,
    input  logic [DATA_W-1:0]       i_tx_data,
    input  logic                    i_rx_done,
    input  logic [DATA_W-1:0]       i_rx_data,
    output logic [CNT_W-1:0]        o_match_cnt,
    output logic [CNT_W-1:0]        o_mismatch_cnt,
    output logic [CNT_W-1:0]        o_unexpected_cnt,
    output logic [CNT_W-1:0]        o_missing_cnt,
    output logic [$clog2(DEPTH):0]  o_pending,
    output logic                    o_overflow,
    output logic                    o_error,
    output logic                    o_err_pulse,
    output logic [DATA_W-1:0]       o_last_exp,
    output logic [DATA_W-1:0]       o_last_got
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [WD_W-1:0]   r_wd;
    logic [CNT_W-1:0]  r_match, r_mismatch, r_unexp, r_missing;
    logic              r_overflow, r_error, r_err_pulse;
    logic [DATA_W-1:0] r_last_exp, r_last_got;

    logic [PTR_W-1:0]  w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [OCC_W-1:0]  w_count_nxt;
    logic [WD_W-1:0]   w_wd_nxt;
    logic [CNT_W-1:0]  w_match_nxt, w_mismatch_nxt, w_unexp_nxt, w_missing_nxt;
    logic              w_overflow_nxt, w_error_nxt, w_err_pulse_nxt;
    logic [DATA_W-1:0] w_last_exp_nxt, w_last_got_nxt;

    logic              w_empty, w_full, w_pop, w_unexp, w_expire, w_remove;
    logic              w_push, w_drop, w_match, w_mismatch;
    logic [DATA_W-1:0] w_head;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == OCC_FULL);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_pop      = i_rx_done && !w_empty;
    assign w_unexp    = i_rx_done && w_empty;
    // An RX strobe in the expiry cycle takes precedence over the timeout.
    assign w_expire   = (TIMEOUT != 0) && !w_empty && !i_rx_done && (r_wd == WD_MAX);
    assign w_remove   = w_pop || w_expire;
    assign w_push     = i_tx_start && (!w_full || w_remove);
    assign w_drop     = i_tx_start && w_full && !w_remove;
    assign w_match    = w_pop && (i_rx_data == w_head);
    assign w_mismatch = w_pop && (i_rx_data != w_head);

    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_wd_nxt        = r_wd;
        w_match_nxt     = r_match;
        w_mismatch_nxt  = r_mismatch;
        w_unexp_nxt     = r_unexp;
        w_missing_nxt   = r_missing;
        w_overflow_nxt  = r_overflow;
        w_error_nxt     = r_error;
        w_err_pulse_nxt = 1'b0;
        w_last_exp_nxt  = r_last_exp;
        w_last_got_nxt  = r_last_got;

        if (i_clr) begin
            w_rd_ptr_nxt   = '0;
            w_wr_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_wd_nxt       = '0;
            w_match_nxt    = '0;
            w_mismatch_nxt = '0;
            w_unexp_nxt    = '0;
            w_missing_nxt  = '0;
            w_overflow_nxt = 1'b0;
            w_error_nxt    = 1'b0;
            w_last_exp_nxt = '0;
            w_last_got_nxt = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end
            if (w_remove) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_remove})
                2'b10:   w_count_nxt = r_count + OCC_W'(1);
                2'b01:   w_count_nxt = r_count - OCC_W'(1);
                default: w_count_nxt = r_count;
            endcase

            if (TIMEOUT == 0 || w_empty || w_remove) begin
                w_wd_nxt = '0;
            end else begin
                w_wd_nxt = r_wd + WD_W'(1);
            end

            if (w_match) begin
                w_match_nxt = sat_inc(r_match);
            end
            if (w_mismatch) begin
                w_mismatch_nxt = sat_inc(r_mismatch);
                w_last_exp_nxt = w_head;
                w_last_got_nxt = i_rx_data;
            end
            if (w_unexp) begin
                w_unexp_nxt = sat_inc(r_unexp);
            end
            if (w_expire) begin
                w_missing_nxt = sat_inc(r_missing);
            end
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end

            w_err_pulse_nxt = w_mismatch || w_unexp || w_expire;
            if (w_err_pulse_nxt || w_drop) begin
                w_error_nxt = 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_wd        <= '0;
            r_match     <= '0;
            r_mismatch  <= '0;
            r_unexp     <= '0;
            r_missing   <= '0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_last_exp  <= '0;
            r_last_got  <= '0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_wd        <= w_wd_nxt;
            r_match     <= w_match_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_unexp     <= w_unexp_nxt;
            r_missing   <= w_missing_nxt;
            r_overflow  <= w_overflow_nxt;
            r_error     <= w_error_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_last_exp  <= w_last_exp_nxt;
            r_last_got  <= w_last_got_nxt;
        end
    end

    assign o_match_cnt      = r_match;
    assign o_mismatch_cnt   = r_mismatch;
    assign o_unexpected_cnt = r_unexp;
    assign o_missing_cnt    = r_missing;
    assign o_pending        = r_count;
    assign o_overflow       = r_overflow;
    assign o_error          = r_error;
    assign o_err_pulse      = r_err_pulse;
    assign o_last_exp       = r_last_exp;
    assign o_last_got       = r_last_got;

endmodule

// File: tb/tb_uart_scoreboard.sv
// Directed bench for uart_scoreboard: one short-watchdog, narrow-counter instance and one
// instance with the watchdog disabled, both driven from the same stimulus.
module tb_uart_scoreboard;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       clr = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [3:0]  a_match, a_mism, a_unexp, a_miss;
    logic [4:0]  a_pending;
    logic        a_ovf, a_err, a_pulse;
    logic [7:0]  a_last_exp, a_last_got;

    logic [15:0] b_match, b_mism, b_unexp, b_miss;
    logic [4:0]  b_pending;
    logic        b_ovf, b_err, b_pulse;
    logic [7:0]  b_last_exp, b_last_got;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_scoreboard #(.DATA_W(8), .DEPTH(16), .CNT_W(4), .TIMEOUT(8)) u_dut_a (
        .i_clk(clk), .i_aresetn(aresetn), .i_clr(clr),
        .i_tx_start(tx_start), .i_tx_data(tx_data),
        .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_match_cnt(a_match), .o_mismatch_cnt(a_mism),
        .o_unexpected_cnt(a_unexp), .o_missing_cnt(a_miss),
        .o_pending(a_pending), .o_overflow(a_ovf), .o_error(a_err),
        .o_err_pulse(a_pulse), .o_last_exp(a_last_exp), .o_last_got(a_last_got)
    );

    uart_scoreboard #(.DATA_W(8), .DEPTH(16), .CNT_W(16), .TIMEOUT(0)) u_dut_b (
        .i_clk(clk), .i_aresetn(aresetn), .i_clr(clr),
        .i_tx_start(tx_start), .i_tx_data(tx_data),
        .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_match_cnt(b_match), .o_mismatch_cnt(b_mism),
        .o_unexpected_cnt(b_unexp), .o_missing_cnt(b_miss),
        .o_pending(b_pending), .o_overflow(b_ovf), .o_error(b_err),
        .o_err_pulse(b_pulse), .o_last_exp(b_last_exp), .o_last_got(b_last_got)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic step(input logic c, input logic tx, input logic [7:0] txd,
                        input logic rx, input logic [7:0] rxd);
        clr      = c;
        tx_start = tx;
        tx_data  = txd;
        rx_done  = rx;
        rx_data  = rxd;
        @(negedge clk);
        clr      = 1'b0;
        tx_start = 1'b0;
        rx_done  = 1'b0;
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_match"}, 32'(a_match), 0);
        check({tag, "_mism"}, 32'(a_mism), 0);
        check({tag, "_unexp"}, 32'(a_unexp), 0);
        check({tag, "_miss"}, 32'(a_miss), 0);
        check({tag, "_pending"}, 32'(a_pending), 0);
        check({tag, "_flags"}, 32'({a_ovf, a_err, a_pulse}), 0);
        check({tag, "_last"}, 32'({a_last_exp, a_last_got}), 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_all_zero_a("rst");
        aresetn = 1'b1;
        @(negedge clk);

        // In-order matches
        step(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA3, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        check("three_pending", 32'(a_pending), 3);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h55);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'hA3);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("match3_cnt", 32'(a_match), 3);
        check("match3_pending", 32'(a_pending), 0);
        check("match3_error", 32'(a_err), 0);
        check("match3_mism", 32'(a_mism), 0);

        // Mismatch
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h3D);
        check("mism_cnt", 32'(a_mism), 1);
        check("mism_exp", 32'(a_last_exp), 32'h3C);
        check("mism_got", 32'(a_last_got), 32'h3D);
        check("mism_pulse", 32'(a_pulse), 1);
        check("mism_error", 32'(a_err), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("mism_pulse_end", 32'(a_pulse), 0);
        check("mism_error_sticky", 32'(a_err), 1);

        // Simultaneous push/pop on empty queue
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("clr_error", 32'(a_err), 0);
        step(1'b0, 1'b1, 8'h11, 1'b1, 8'h11);
        check("unexp_cnt", 32'(a_unexp), 1);
        check("unexp_pending", 32'(a_pending), 1);
        check("unexp_pulse", 32'(a_pulse), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
        check("unexp_then_match", 32'(a_match), 1);
        check("unexp_then_pending", 32'(a_pending), 0);

        // Overflow on the watchdog-free instance
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
        check("ovf_pending", 32'(b_pending), 16);
        check("ovf_flag", 32'(b_ovf), 1);
        check("ovf_error", 32'(b_err), 1);
        check("ovf_no_pulse", 32'(b_pulse), 0);
        step(1'b0, 1'b1, 8'hEE, 1'b1, 8'h00);
        check("full_pushpop_pending", 32'(b_pending), 16);
        check("full_pushpop_ovf", 32'(b_ovf), 1);
        check("full_pushpop_match", 32'(b_match), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
        check("full_order_match", 32'(b_match), 2);
        check("full_order_mism", 32'(b_mism), 0);

        // Watchdog expiry 8 cycles after the push
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wd_before_miss", 32'(a_miss), 0);
        check("wd_before_pending", 32'(a_pending), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wd_miss", 32'(a_miss), 1);
        check("wd_pending", 32'(a_pending), 0);
        check("wd_pulse", 32'(a_pulse), 1);
        check("wd_error", 32'(a_err), 1);

        // RX in the expiry cycle wins
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h78, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h78);
        check("wd_rx_match", 32'(a_match), 1);
        check("wd_rx_miss", 32'(a_miss), 0);
        check("wd_rx_pending", 32'(a_pending), 0);
        check("wd_rx_error", 32'(a_err), 0);

        // Saturation
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(i + 8'h40), 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00, 1'b1, 8'(i + 8'h40));
        end
        check("sat_match_4b", 32'(a_match), 15);
        check("sat_match_16b", 32'(b_match), 20);
        check("sat_error", 32'(a_err), 0);

        // Clear wins over a same-cycle push
        step(1'b0, 1'b1, 8'h99, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h9A, 1'b0, 8'h00);
        check_all_zero_a("clr");

        // Asynchronous reset mid-stream
        step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h5B, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("pre_rst_pending", 32'(a_pending), 1);
        check("pre_rst_pulse", 32'(a_pulse), 1);
        #2 aresetn = 1'b0;
        #1 check_all_zero_a("arst");
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        check_all_zero_a("post_arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
